// File: rtl/aes128_iter_core.sv
// Iterative AES-128 encryptor: valid/ready on both sides, on-the-fly key expansion,
// ROUNDS_PER_CYCLE rounds unrolled per clock, sideband tag carried with each block.
module aes128_iter_core #(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter int TAG_W            = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [127:0]     in_data_i,
  input  logic [127:0]     in_key_i,
  input  logic [TAG_W-1:0] in_tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [127:0]     out_data_o,
  output logic [TAG_W-1:0] out_tag_o,
  output logic             busy_o
);

  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
        ROUNDS_PER_CYCLE == 5 || ROUNDS_PER_CYCLE == 10)) begin : g_bad_rpc
    $error("aes128_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("aes128_iter_core: TAG_W must be >= 1");
  end

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry b sits at bits [2047-8b -: 8], and 2047-8b == {~b, 3'b111}.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    sbox = SBOX[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    mix_col = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
               a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
               a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
               xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s,
                                             input logic [127:0] rk,
                                             input logic         last);
    logic [127:0] sr;
    logic [127:0] mc;
    sr = '0;
    mc = '0;
    // Byte (row r, col c) lives at index 4c+r; ShiftRows pulls from column (c+r) mod 4.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
      end
    end
    for (int c = 0; c < 4; c++) begin
      mc[127-32*c -: 32] = mix_col(sr[127-32*c -: 32]);
    end
    aes_round = (last ? sr : mc) ^ rk;
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rcon);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t  = {sbox(w3[23:16]) ^ rcon, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    next_key = {w0, w1, w2, w3};
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

  fsm_e             fsm_q;
  logic [127:0]     state_q, key_q, out_data_q;
  logic [7:0]       rcon_q;
  logic [3:0]       rnd_q;
  logic [TAG_W-1:0] tag_q, out_tag_q;
  logic             out_valid_q;

  logic [127:0]     state_d, key_d;
  logic [7:0]       rcon_d;
  logic             accept;
  logic             last_step;

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    rcon_d  = rcon_q;
    for (int i = 0; i < ROUNDS_PER_CYCLE; i++) begin
      key_d   = next_key(key_d, rcon_d);
      state_d = aes_round(state_d, key_d, (rnd_q + 4'(i)) == 4'd10);
      rcon_d  = xtime(rcon_d);
    end
  end

  assign in_ready_o  = (fsm_q == IDLE) || ((fsm_q == DONE) && out_ready_i);
  assign accept      = in_valid_i && in_ready_o;
  assign last_step   = (rnd_q == 4'(11 - ROUNDS_PER_CYCLE));
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_tag_o   = out_tag_q;
  assign busy_o      = (fsm_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= IDLE;
      state_q     <= '0;
      key_q       <= '0;
      rcon_q      <= '0;
      rnd_q       <= '0;
      tag_q       <= '0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (fsm_q)
        IDLE: ;
        RUN: begin
          state_q <= state_d;
          key_q   <= key_d;
          rcon_q  <= rcon_d;
          if (last_step) begin
            out_data_q  <= state_d;
            out_tag_q   <= tag_q;
            out_valid_q <= 1'b1;
            fsm_q       <= DONE;
          end else begin
            rnd_q <= rnd_q + 4'(ROUNDS_PER_CYCLE);
          end
        end
        DONE: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            fsm_q       <= IDLE;
          end
        end
        default: fsm_q <= IDLE;
      endcase
      // A new block can be taken on the same edge that hands off the previous result.
      if (accept) begin
        state_q <= in_data_i ^ in_key_i;
        key_q   <= in_key_i;
        tag_q   <= in_tag_i;
        rnd_q   <= 4'd1;
        rcon_q  <= 8'h01;
        fsm_q   <= RUN;
      end
    end
  end

endmodule

// File: tb/tb_aes128_iter_core.sv
// Directed bench for aes128_iter_core: FIPS-197 vectors, handshake hold, back-to-back,
// mid-run reset, input sampling, and latency for every legal ROUNDS_PER_CYCLE.
module tb_aes128_iter_core;

  localparam int RPC = 1;
  localparam int N   = 10 / RPC;

  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P1 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P2 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C3 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [127:0] in_key;
  logic [3:0]   in_tag;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [3:0]   out_tag;
  logic         busy;

  logic         v_valid     [3];
  logic         v_ready     [3];
  logic         v_in_ready  [3];
  logic         v_out_valid [3];
  logic [127:0] v_out_data  [3];
  logic [3:0]   v_out_tag   [3];
  logic         v_busy      [3];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  aes128_iter_core #(.ROUNDS_PER_CYCLE(RPC), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_data_i(in_data), .in_key_i(in_key), .in_tag_i(in_tag),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .out_tag_o(out_tag), .busy_o(busy)
  );

  for (genvar g = 0; g < 3; g++) begin : g_var
    aes128_iter_core #(.ROUNDS_PER_CYCLE(g == 0 ? 2 : (g == 1 ? 5 : 10)), .TAG_W(4)) u_var (
      .clk(clk), .rst_n(rst_n),
      .in_valid_i(v_valid[g]), .in_ready_o(v_in_ready[g]),
      .in_data_i(in_data), .in_key_i(in_key), .in_tag_i(in_tag),
      .out_valid_o(v_out_valid[g]), .out_ready_i(v_ready[g]),
      .out_data_o(v_out_data[g]), .out_tag_o(v_out_tag[g]), .busy_o(v_busy[g])
    );
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic [127:0] d, input logic [127:0] k, input logic [3:0] t);
    in_data  = d;
    in_key   = k;
    in_tag   = t;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_key = '0; in_tag = '0;
    for (int g = 0; g < 3; g++) begin v_valid[g] = 1'b0; v_ready[g] = 1'b0; end
    step(); step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 128'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    checks++; if (out_tag !== 4'h0) begin failures++; $display("FAIL reset_out_tag got=%h exp=0", out_tag); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_fips();
    int n;
    send(P1, K1, 4'h3);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL t1_busy got=%b exp=1", busy); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL t1_in_ready_run got=%b exp=0", in_ready); end
    wait_out(n);
    checks++; if (n != N) begin failures++; $display("FAIL t1_latency got=%0d exp=%0d", n, N); end
    checks++; if (out_data !== C1) begin failures++; $display("FAIL t1_data got=%h exp=%h", out_data, C1); end
    checks++; if (out_tag !== 4'h3) begin failures++; $display("FAIL t1_tag got=%h exp=3", out_tag); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL t1_drop got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL t1_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_rpc_variants();
    int n;
    int lat;
    for (int g = 0; g < 3; g++) begin
      lat = (g == 0) ? 5 : ((g == 1) ? 2 : 1);
      in_data = P1; in_key = K1; in_tag = 4'(g + 1);
      v_valid[g] = 1'b1;
      step();
      v_valid[g] = 1'b0;
      in_data = '0; in_key = '0;
      n = 0;
      while (!v_out_valid[g] && n < 40) begin step(); n++; end
      checks++; if (n != lat) begin failures++; $display("FAIL rpc_latency[%0d] got=%0d exp=%0d", g, n, lat); end
      checks++; if (v_out_data[g] !== C1) begin failures++; $display("FAIL rpc_data[%0d] got=%h exp=%h", g, v_out_data[g], C1); end
      checks++; if (v_out_tag[g] !== 4'(g + 1)) begin failures++; $display("FAIL rpc_tag[%0d] got=%h exp=%h", g, v_out_tag[g], 4'(g + 1)); end
      v_ready[g] = 1'b1;
      step();
      v_ready[g] = 1'b0;
      checks++; if (v_out_valid[g] !== 1'b0) begin failures++; $display("FAIL rpc_drop[%0d] got=%b exp=0", g, v_out_valid[g]); end
    end
  endtask

  task automatic test_tag();
    int n;
    send(P2, K2, 4'h5);
    wait_out(n);
    checks++; if (out_data !== C2) begin failures++; $display("FAIL t2_data got=%h exp=%h", out_data, C2); end
    checks++; if (out_tag !== 4'h5) begin failures++; $display("FAIL t2_tag got=%h exp=5", out_tag); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_hold();
    int n;
    send(128'h0, 128'h0, 4'ha);
    wait_out(n);
    checks++; if (out_data !== C3) begin failures++; $display("FAIL t3_data got=%h exp=%h", out_data, C3); end
    in_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_data = {$urandom, $urandom, $urandom, $urandom};
      in_key  = {$urandom, $urandom, $urandom, $urandom};
      step();
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL t3_hold_valid[%0d] got=%b exp=1", i, out_valid); end
      checks++; if (out_data !== C3) begin failures++; $display("FAIL t3_hold_data[%0d] got=%h exp=%h", i, out_data, C3); end
      checks++; if (out_tag !== 4'ha) begin failures++; $display("FAIL t3_hold_tag[%0d] got=%h exp=a", i, out_tag); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL t3_hold_in_ready[%0d] got=%b exp=0", i, in_ready); end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL t3_release got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    int n;
    int last_acc;
    logic [127:0] exp_d;
    last_acc  = 0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      n = 0;
      while (!in_ready && n < 40) begin step(); n++; end
      if (i > 0) begin
        exp_d = ((i - 1) % 2 == 0) ? C1 : C2;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid[%0d] got=%b exp=1", i - 1, out_valid); end
        checks++; if (out_data !== exp_d) begin failures++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i - 1, out_data, exp_d); end
        checks++; if (out_tag !== 4'(i - 1)) begin failures++; $display("FAIL b2b_tag[%0d] got=%h exp=%h", i - 1, out_tag, 4'(i - 1)); end
        checks++; if (cyc - last_acc != N + 1) begin failures++; $display("FAIL b2b_period[%0d] got=%0d exp=%0d", i - 1, cyc - last_acc, N + 1); end
      end
      if (i < 8) begin
        in_data  = (i % 2 == 0) ? P1 : P2;
        in_key   = (i % 2 == 0) ? K1 : K2;
        in_tag   = 4'(i);
        last_acc = cyc;
        step();
      end else begin
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_final_drop got=%b exp=0", out_valid); end
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n;
    logic seen;
    send(P2, K2, 4'h6);
    step(); step(); step();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL t5_busy_run got=%b exp=1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL t5_rst_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL t5_rst_busy got=%b exp=0", busy); end
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL t5_aborted_output got=%b exp=0", seen); end
    out_ready = 1'b0;
    send(P2, K2, 4'h5);
    wait_out(n);
    checks++; if (n != N) begin failures++; $display("FAIL t5_latency got=%0d exp=%0d", n, N); end
    checks++; if (out_data !== C2) begin failures++; $display("FAIL t5_data got=%h exp=%h", out_data, C2); end
    checks++; if (out_tag !== 4'h5) begin failures++; $display("FAIL t5_tag got=%h exp=5", out_tag); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_sampling();
    int n;
    send(P1, K1, 4'h9);
    n = 0;
    while (!out_valid && n < 40) begin
      in_data = {$urandom, $urandom, $urandom, $urandom};
      in_key  = {$urandom, $urandom, $urandom, $urandom};
      in_tag  = 4'($urandom);
      step();
      n++;
    end
    checks++; if (n != N) begin failures++; $display("FAIL t6_latency got=%0d exp=%0d", n, N); end
    checks++; if (out_data !== C1) begin failures++; $display("FAIL t6_data got=%h exp=%h", out_data, C1); end
    checks++; if (out_tag !== 4'h9) begin failures++; $display("FAIL t6_tag got=%h exp=9", out_tag); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fips();
    test_rpc_variants();
    test_tag();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_sampling();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
